instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq_pkg.sv | 41 ++++
 rtl/instr_seq_if.sv | 12 +
 rtl/instr_seq.sv | 123 ++++++++++++
 tb/tb_instr_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: instruction classes,
// FSM states and the bit positions of every instruction field.
package instr_seq_pkg;

   typedef enum logic [1:0] {
      CLS_LOAD = 2'b00,
      CLS_ALU  = 2'b01,
      CLS_NOP  = 2'b10,
      CLS_HALT = 2'b11
   } instr_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LDIMM = 2'b01,
      ST_HALT  = 2'b10
   } state_e;

   localparam int INSTR_W   = 16;

   localparam int CLS_HI    = 15;
   localparam int CLS_LO    = 14;

   // ALU word layout; bits [2:0] carry no meaning.
   localparam int ALU_OP_HI = 13;
   localparam int ALU_OP_LO = 12;
   localparam int ALU_RA_HI = 11;
   localparam int ALU_RA_LO = 9;
   localparam int ALU_RB_HI = 8;
   localparam int ALU_RB_LO = 6;
   localparam int ALU_WA_HI = 5;
   localparam int ALU_WA_LO = 3;

   // LOAD word layout; the word after a LOAD is the immediate itself.
   localparam int LD_WA_HI  = 13;
   localparam int LD_WA_LO  = 11;

   function automatic instr_cls_e get_cls(input logic [INSTR_W-1:0] word);
      return instr_cls_e'(word[CLS_HI:CLS_LO]);
   endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Upstream instruction stream: valid/ready handshake carrying one 16-bit word.
interface instr_seq_if;
   import instr_seq_pkg::*;

   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/instr_seq.sv
// Instruction sequencer: decodes a word stream into register-file/ALU write
// strobes, handles two-word LOAD immediates, HALT/go and issue status.
module instr_seq
   import instr_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   instr_seq_if.slave         ibus,
   input  logic               go,
   input  logic               alu_cout,
   output logic [1:0]         op,
   output logic [2:0]         rd_addr_a,
   output logic [2:0]         rd_addr_b,
   output logic [2:0]         wr_addr,
   output logic               wr,
   output logic               sel,
   output logic [INSTR_W-1:0] d_out,
   output logic               carry,
   output logic               halted,
   output logic [CNT_W-1:0]   issue_cnt
);

   state_e     state_q, state_d;
   logic       rdy_en_q;
   logic [2:0] ld_addr_q, ld_addr_d;
   logic       accept;
   logic       iss_alu;
   logic       iss_imm;

   // ready stays low until the first edge after reset release
   assign ibus.instr_ready = rdy_en_q && (state_q != ST_HALT);
   assign accept           = ibus.instr_valid && ibus.instr_ready;
   assign halted           = (state_q == ST_HALT);

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      ld_addr_d = ld_addr_q;
      iss_alu   = 1'b0;
      iss_imm   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unique case (get_cls(ibus.instr))
                  CLS_LOAD: begin
                     ld_addr_d = ibus.instr[LD_WA_HI:LD_WA_LO];
                     state_d   = ST_LDIMM;
                  end
                  CLS_ALU:  iss_alu = 1'b1;
                  CLS_HALT: state_d = ST_HALT;
                  default:  ;
               endcase
            end
         end
         ST_LDIMM: begin
            // no decode here: every accepted word is immediate data
            if (accept) begin
               iss_imm = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (go) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         rdy_en_q  <= 1'b0;
         ld_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rdy_en_q  <= 1'b1;
         ld_addr_q <= ld_addr_d;
      end
   end

   // Datapath strobes: wr is a one-cycle pulse, the rest hold between issues.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr        <= 1'b0;
         sel       <= 1'b0;
         op        <= '0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         wr_addr   <= '0;
         d_out     <= '0;
      end else begin
         wr <= iss_alu || iss_imm;
         if (iss_alu) begin
            sel       <= 1'b1;
            op        <= ibus.instr[ALU_OP_HI:ALU_OP_LO];
            rd_addr_a <= ibus.instr[ALU_RA_HI:ALU_RA_LO];
            rd_addr_b <= ibus.instr[ALU_RB_HI:ALU_RB_LO];
            wr_addr   <= ibus.instr[ALU_WA_HI:ALU_WA_LO];
         end else if (iss_imm) begin
            sel     <= 1'b0;
            wr_addr <= ld_addr_q;
            d_out   <= ibus.instr;
         end
      end
   end

   // carry follows the ALU during its write cycle; counter counts every write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         carry     <= 1'b0;
         issue_cnt <= '0;
      end else if (wr) begin
         issue_cnt <= issue_cnt + CNT_W'(1);
         if (sel) carry <= alu_cout;
      end
   end

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: a word-level reference model checked on every
// falling edge, plus literal expectations at key points of each scenario.
module tb_instr_seq;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             go = 1'b0;
   logic             alu_cout = 1'b0;
   logic [1:0]       op;
   logic [2:0]       rd_addr_a, rd_addr_b, wr_addr;
   logic             wr, sel, carry, halted;
   logic [15:0]      d_out;
   logic [CNT_W-1:0] issue_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   instr_seq_if bus ();

   instr_seq #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .ibus      (bus),
      .go        (go),
      .alu_cout  (alu_cout),
      .op        (op),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_addr   (wr_addr),
      .wr        (wr),
      .sel       (sel),
      .d_out     (d_out),
      .carry     (carry),
      .halted    (halted),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks whether an immediate is owed and whether the
   // sequencer is halted, and what the downstream datapath must see.
   bit               m_rdy, m_wait, m_halted, m_acc;
   bit [2:0]         m_ld;
   bit               e_wr, e_sel;
   bit [1:0]         e_op;
   bit [2:0]         e_ra, e_rb, e_wa;
   bit [15:0]        e_d;
   bit               e_carry;
   bit [CNT_W-1:0]   e_cnt;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_rdy = 0; m_wait = 0; m_halted = 0; m_ld = 0;
         e_wr = 0; e_sel = 0; e_op = 0; e_ra = 0; e_rb = 0; e_wa = 0; e_d = 0;
         e_carry = 0; e_cnt = 0;
      end else begin
         m_acc = bus.instr_valid && m_rdy && !m_halted;
         if (e_wr) begin
            e_cnt = e_cnt + 1'b1;
            if (e_sel) e_carry = alu_cout;
         end
         e_wr = 0;
         if (m_halted) begin
            if (go) m_halted = 0;
         end else if (m_acc) begin
            if (m_wait) begin
               e_wr = 1; e_sel = 0; e_d = bus.instr; e_wa = m_ld; m_wait = 0;
            end else begin
               case (bus.instr[15:14])
                  2'b00: begin m_ld = bus.instr[13:11]; m_wait = 1; end
                  2'b01: begin
                     e_wr = 1; e_sel = 1;
                     e_op = bus.instr[13:12];
                     e_ra = bus.instr[11:9];
                     e_rb = bus.instr[8:6];
                     e_wa = bus.instr[5:3];
                  end
                  2'b11: m_halted = 1;
                  default: ;
               endcase
            end
         end
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      check("ready",     32'(bus.instr_ready), 32'(m_rdy && !m_halted));
      check("wr",        32'(wr),        32'(e_wr));
      check("sel",       32'(sel),       32'(e_sel));
      check("op",        32'(op),        32'(e_op));
      check("rd_addr_a", 32'(rd_addr_a), 32'(e_ra));
      check("rd_addr_b", 32'(rd_addr_b), 32'(e_rb));
      check("wr_addr",   32'(wr_addr),   32'(e_wa));
      check("d_out",     32'(d_out),     32'(e_d));
      check("carry",     32'(carry),     32'(e_carry));
      check("halted",    32'(halted),    32'(m_halted));
      check("issue_cnt", 32'(issue_cnt), 32'(e_cnt));
   end

   // One cycle of stimulus; returns just after the edge that consumed it.
   task automatic step(input bit v, input logic [15:0] w, input bit g, input bit c);
      bus.instr_valid = v;
      bus.instr       = w;
      go              = g;
      alu_cout        = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1 reset = 1'b0;
      #1;
      check("rst_ready", 32'(bus.instr_ready), 32'd0);
      check("rst_wr",    32'(wr),        32'd0);
      check("rst_cnt",   32'(issue_cnt), 32'd0);
      check("rst_halt",  32'(halted),    32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      step(0, 16'h0, 0, 0);
      check("rel_ready", 32'(bus.instr_ready), 32'd1);
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // ALU issue with hand-decoded fields
      step(1, 16'h4A50, 0, 0);
      check("alu_wr",   32'(wr),        32'd1);
      check("alu_sel",  32'(sel),       32'd1);
      check("alu_op",   32'(op),        32'd0);
      check("alu_ra",   32'(rd_addr_a), 32'd5);
      check("alu_rb",   32'(rd_addr_b), 32'd1);
      check("alu_wa",   32'(wr_addr),   32'd2);
      step(0, 16'h0, 0, 0);
      check("alu_wr_off", 32'(wr),        32'd0);
      check("alu_cnt",    32'(issue_cnt), 32'd1);

      // NOP, then go while not halted (ignored)
      step(1, 16'h8000, 0, 0);
      check("nop_wr", 32'(wr), 32'd0);
      step(0, 16'h0, 1, 0);

      // LOAD then immediate
      step(1, 16'h2800, 0, 0);
      check("ld_wr0", 32'(wr), 32'd0);
      step(1, 16'hBEEF, 0, 0);
      check("imm_wr",  32'(wr),      32'd1);
      check("imm_sel", 32'(sel),     32'd0);
      check("imm_wa",  32'(wr_addr), 32'd5);
      check("imm_d",   32'(d_out),   32'hBEEF);
      step(0, 16'h0, 0, 0);
      check("imm_wr_off", 32'(wr), 32'd0);

      // LOAD, long stall, then a HALT-looking word taken as data
      step(1, 16'h1800, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 16'hC000, 0, 0);
      step(1, 16'hC123, 0, 0);
      check("stall_wr",   32'(wr),     32'd1);
      check("stall_d",    32'(d_out),  32'hC123);
      check("stall_wa",   32'(wr_addr), 32'd3);
      check("stall_halt", 32'(halted), 32'd0);

      // HALT ignores words until go
      step(1, 16'hC000, 0, 0);
      check("halt_flag",  32'(halted),            32'd1);
      check("halt_ready", 32'(bus.instr_ready),   32'd0);
      step(1, 16'h4A50, 0, 0);
      step(1, 16'h5FF8, 0, 0);
      check("halt_nowr", 32'(wr), 32'd0);
      step(0, 16'h0, 1, 0);
      check("go_halt",  32'(halted),          32'd0);
      check("go_ready", 32'(bus.instr_ready), 32'd1);
      step(1, 16'h7A50, 0, 0);
      check("go_wr", 32'(wr), 32'd1);
      check("go_op", 32'(op), 32'd3);

      // carry tracking: ALU cout 1, ALU cout 0, LOAD issue with cout 1
      step(1, 16'h5248, 0, 0);
      step(1, 16'h6248, 0, 1);
      check("carry_1", 32'(carry), 32'd1);
      step(0, 16'h0, 0, 0);
      check("carry_0", 32'(carry), 32'd0);
      step(1, 16'h0800, 0, 1);
      step(1, 16'h1234, 0, 1);
      step(0, 16'h0, 0, 1);
      check("carry_ld", 32'(carry), 32'd0);

      // reset while an immediate is owed discards it
      step(1, 16'h2800, 0, 0);
      do_reset();
      step(1, 16'h1234, 0, 0);
      check("rst_ld_wr", 32'(wr), 32'd0);
      step(0, 16'h0, 0, 0);
      check("rst_ld_wr2", 32'(wr), 32'd0);

      // 17 back-to-back ALU issues wrap the 4-bit counter to 1
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 16'h4000 | 16'(i << 3), 0, 0);
      step(0, 16'h0, 0, 0);
      check("wrap_cnt", 32'(issue_cnt), 32'd1);
      step(0, 16'h0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
